// File: rtl/dem_bcd_1hz_sw.sv
// 1 Hz tick consumer: edge-detects f and runs a 2-digit BCD up/down counter under switch control.
// Optional switch debouncing is enabled by defining DEBOUNCE_EN.
module dem_bcd_1hz_sw #(
    parameter int MAX_TENS = 5,
    parameter int MAX_ONES = 9,
    parameter int DB_N     = 20,
    parameter int DB_MAX   = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       f,
    input  logic       sw_run,
    input  logic       sw_dir,
    input  logic       sw_clr,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       tick_o,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10,
        ST_HOLD = 2'b11
    } state_t;

    localparam logic [3:0] MAX_T = 4'(MAX_TENS);
    localparam logic [3:0] MAX_O = 4'(MAX_ONES);

    state_t     state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       tick_o_q, tick_o_d;
    logic       f_d_q;
    logic       tick;

    logic [2:0] sw_raw;
    logic [2:0] sync1_q, sync2_q;
    logic [2:0] stable;
    logic       run_s, dir_s, clr_s;

    // ------------------------------------------------------------------
    // Tick: f is already in the clk domain, so a single delay flop suffices.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) f_d_q <= 1'b0;
        else       f_d_q <= f;
    end

    assign tick = f & ~f_d_q;

    // ------------------------------------------------------------------
    // Switch synchronisers, bit order {clr, dir, run}
    // ------------------------------------------------------------------
    assign sw_raw = {sw_clr, sw_dir, sw_run};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
        end
    end

    genvar gi;
`ifdef DEBOUNCE_EN
    generate
        for (gi = 0; gi < 3; gi++) begin : g_db
            logic [DB_N-1:0] cnt_q, cnt_d;
            logic            stab_q, stab_d;

            // Counter only advances while the synchronised level disagrees with the stable one.
            always_comb begin
                cnt_d  = '0;
                stab_d = stab_q;
                if (sync2_q[gi] != stab_q) begin
                    if (cnt_q == DB_N'(DB_MAX - 1)) begin
                        stab_d = sync2_q[gi];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q  <= '0;
                    stab_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    stab_q <= stab_d;
                end
            end

            assign stable[gi] = stab_q;
        end
    endgenerate
`else
    generate
        for (gi = 0; gi < 3; gi++) begin : g_nodb
            assign stable[gi] = sync2_q[gi];
        end
    endgenerate
`endif

    // Elaboration-time sanity hook on the debounce sizing; intentionally empty.
    generate
        if (DB_MAX < 1 || DB_N < 1) begin : g_db_param_bad
        end
    endgenerate

    assign run_s = stable[0];
    assign dir_s = stable[1];
    assign clr_s = stable[2];

    // ------------------------------------------------------------------
    // BCD step candidates
    // ------------------------------------------------------------------
    logic [3:0] up_tens, up_ones, dn_tens, dn_ones;

    always_comb begin
        up_tens = tens_q;
        up_ones = ones_q;
        if (tens_q == MAX_T && ones_q == MAX_O) begin
            up_tens = 4'd0;
            up_ones = 4'd0;
        end else if (ones_q == 4'd9) begin
            up_ones = 4'd0;
            up_tens = tens_q + 4'd1;
        end else begin
            up_ones = ones_q + 4'd1;
        end
    end

    always_comb begin
        dn_tens = tens_q;
        dn_ones = ones_q;
        if (tens_q == 4'd0 && ones_q == 4'd0) begin
            dn_tens = MAX_T;
            dn_ones = MAX_O;
        end else if (ones_q == 4'd0) begin
            dn_ones = 4'd9;
            dn_tens = tens_q - 4'd1;
        end else begin
            dn_ones = ones_q - 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // FSM: the tick is applied according to the current state; a state
    // change decided in the same cycle only takes effect next cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        tick_o_d = 1'b0;

        if (clr_s) begin
            state_d = ST_IDLE;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tens_d = 4'd0;
                    ones_d = 4'd0;
                    if (run_s) state_d = dir_s ? ST_UP : ST_DOWN;
                end
                ST_UP: begin
                    if (tick) begin
                        tens_d = up_tens;
                        ones_d = up_ones;
                    end
                    if (!run_s)      state_d = ST_HOLD;
                    else if (!dir_s) state_d = ST_DOWN;
                end
                ST_DOWN: begin
                    if (tick) begin
                        tens_d = dn_tens;
                        ones_d = dn_ones;
                    end
                    if (!run_s)     state_d = ST_HOLD;
                    else if (dir_s) state_d = ST_UP;
                end
                ST_HOLD: begin
                    if (run_s) state_d = dir_s ? ST_UP : ST_DOWN;
                end
                default: state_d = ST_IDLE;
            endcase

            tick_o_d = tick && (state_q == ST_UP || state_q == ST_DOWN) &&
                       ({tens_d, ones_d} != {tens_q, ones_q});
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            tens_q   <= 4'd0;
            ones_q   <= 4'd0;
            tick_o_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            tick_o_q <= tick_o_d;
        end
    end

    assign tens   = tens_q;
    assign ones   = ones_q;
    assign tick_o = tick_o_q;
    assign state  = state_q;

endmodule

// File: tb/tb_dem_bcd_1hz_sw.sv
// Directed bench for dem_bcd_1hz_sw: expected counts are queued per f edge and checked on tick_o.
// Switch latency tracks DEBOUNCE_EN so the same sequence works in both builds.
module tb_dem_bcd_1hz_sw;

    localparam int DB_MAX = 4;
`ifdef DEBOUNCE_EN
    localparam int SW_LAT = 2 + DB_MAX;
`else
    localparam int SW_LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       reset, f, sw_run, sw_dir, sw_clr;
    logic [3:0] tens, ones;
    logic       tick_o;
    logic [1:0] state;

    int tests    = 0;
    int failed   = 0;
    int tick_cnt = 0;
    int m        = 0;
    int t0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_pop;

    dem_bcd_1hz_sw #(.DB_MAX(DB_MAX)) dut (
        .clk(clk), .reset(reset), .f(f),
        .sw_run(sw_run), .sw_dir(sw_dir), .sw_clr(sw_clr),
        .tens(tens), .ones(ones), .tick_o(tick_o), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One rising edge of f held high for 'high' clocks; adv is the expected count move.
    task automatic f_edge(input int high, input int adv);
        f = 1'b1;
        if (adv != 0) begin
            m = (m + adv + 60) % 60;
            exp_q.push_back(to_bcd(m));
        end
        step(high);
        f = 1'b0;
        step(2);
    endtask

    always @(negedge clk) begin
        if (!reset && tick_o === 1'b1) begin
            tick_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_tick", int'({tens, ones}), -1);
            end else begin
                exp_pop = exp_q.pop_front();
                $display("[TB] tick count=%h%h expected=%h", tens, ones, exp_pop);
                chk("tick_count", int'({tens, ones}), int'(exp_pop));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; f = 1'b0; sw_run = 1'b0; sw_dir = 1'b0; sw_clr = 1'b0;
        step(2);
        chk("rst_state", int'(state), 0);
        chk("rst_count", int'({tens, ones}), 0);
        chk("rst_tick", int'(tick_o), 0);

        // 1: count up from reset
        reset = 1'b0; sw_run = 1'b1; sw_dir = 1'b1;
        step(SW_LAT + 2);
        chk("t1_state_up", int'(state), 1);
        for (int i = 1; i <= 3; i++) begin
            f_edge(1, 1);
            chk("t1_count", int'({tens, ones}), i);
        end
        chk("t1_ticks3", tick_cnt, 3);
        f_edge(10, 1);
        chk("t1_long_f_one_tick", tick_cnt, 4);
        chk("t1_count04", int'({tens, ones}), 'h04);

        // 2: carry and wrap going up
        while (m != 9) f_edge(1, 1);
        chk("t2_count09", int'({tens, ones}), 'h09);
        f_edge(1, 1);
        chk("t2_carry10", int'({tens, ones}), 'h10);
        while (m != 58) f_edge(1, 1);
        f_edge(1, 1);
        chk("t2_count59", int'({tens, ones}), 'h59);
        f_edge(1, 1);
        chk("t2_wrap00", int'({tens, ones}), 'h00);

        // 3: clear, then count down from IDLE
        sw_clr = 1'b1;
        step(SW_LAT + 2);
        chk("t3_clr_state", int'(state), 0);
        chk("t3_clr_count", int'({tens, ones}), 0);
        m = 0;
        sw_dir = 1'b0; sw_clr = 1'b0;
        step(SW_LAT + 2);
        chk("t3_state_down", int'(state), 2);
        f_edge(1, -1);
        chk("t3_wrap59", int'({tens, ones}), 'h59);
        while (m != 10) f_edge(1, -1);
        f_edge(1, -1);
        chk("t3_borrow09", int'({tens, ones}), 'h09);
        f_edge(1, -1);
        f_edge(1, -1);
        chk("t3_count07", int'({tens, ones}), 'h07);

        // 4: HOLD freezes the count
        sw_run = 1'b0;
        step(SW_LAT + 2);
        chk("t4_state_hold", int'(state), 3);
        t0 = tick_cnt;
        repeat (5) f_edge(1, 0);
        chk("t4_hold_count", int'({tens, ones}), 'h07);
        chk("t4_hold_no_tick", tick_cnt, t0);
        sw_run = 1'b1; sw_dir = 1'b1;
        step(SW_LAT + 2);
        chk("t4_state_up", int'(state), 1);
        f_edge(1, 1);
        chk("t4_count08", int'({tens, ones}), 'h08);

        // 5: clear coinciding with a tick, then async reset mid-count
        while (m != 42) f_edge(1, 1);
        chk("t5_count42", int'({tens, ones}), 'h42);
        sw_clr = 1'b1;
        step(SW_LAT);
        f = 1'b1;
        step(1);
        chk("t5_clr_count", int'({tens, ones}), 0);
        chk("t5_clr_state", int'(state), 0);
        chk("t5_clr_tick", int'(tick_o), 0);
        f = 1'b0;
        step(2);
        sw_clr = 1'b0;
        m = 0;
        step(SW_LAT + 2);
        while (m != 33) f_edge(1, 1);
        chk("t5_count33", int'({tens, ones}), 'h33);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t5_async_count", int'({tens, ones}), 0);
        chk("t5_async_state", int'(state), 0);
        step(1);
        chk("t5_queue_empty", exp_q.size(), 0);

        // 6: switch-to-state latency (and glitch rejection when debouncing)
        sw_run = 1'b0;
        reset = 1'b0;
        step(SW_LAT + 2);
        chk("t6_idle", int'(state), 0);
`ifdef DEBOUNCE_EN
        sw_run = 1'b1;
        step(3);
        sw_run = 1'b0;
        step(SW_LAT + 4);
        chk("t6_glitch_rejected", int'(state), 0);
`endif
        sw_run = 1'b1;
        step(SW_LAT);
        chk("t6_lat_before", int'(state), 0);
        step(1);
        chk("t6_lat_after", int'(state), 1);

        chk("end_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
